// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the requesters/memory environment and dmem_arbiter.
//   master : the environment side -- drives both request ports and the
//            memory read data, observes acks/results and the memory strobes.
//   slave  : the arbiter side.
// Port 0 = CPU load/store unit, port 1 = secondary master (DMA/debug).
interface dmem_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  f3_0, f3_1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_func3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data_out;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, f3_0, f3_1,
    output mem_data_out,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  mem_addr, mem_write_data, mem_func3, mem_read, mem_write
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, f3_0, f3_1,
    input  mem_data_out,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output mem_addr, mem_write_data, mem_func3, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the byte-addressed data memory.
// Each granted access is checked (func3 legality, alignment, range), then
// issued as a single read or write strobe and answered with a one-cycle ack.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_arbiter_if.slave -- req/we/addr/wdata/f3 in per port,
//              ack/err/rdata out per port, mem_* towards the memory.
// Parameter DEPTH: memory size in bytes (legal addresses 0..DEPTH-1).
module dmem_arbiter #(
  parameter int unsigned DEPTH = 1024
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        err_q, err_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        pick;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_f3;
  logic        s_legal, s_misalign, s_oor, s_err;
  logic [32:0] s_size;

  // Selection and legality check of the candidate port
  always_comb begin
    pick    = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    s_we    = pick ? bus.we1    : bus.we0;
    s_addr  = pick ? bus.addr1  : bus.addr0;
    s_wdata = pick ? bus.wdata1 : bus.wdata0;
    s_f3    = pick ? bus.f3_1   : bus.f3_0;

    if (s_we) s_legal = (s_f3 == 3'b000) || (s_f3 == 3'b001) || (s_f3 == 3'b010);
    else      s_legal = (s_f3 == 3'b000) || (s_f3 == 3'b001) || (s_f3 == 3'b010) ||
                        (s_f3 == 3'b100) || (s_f3 == 3'b101);

    case (s_f3[1:0])
      2'b00:   s_size = 33'd1;
      2'b01:   s_size = 33'd2;
      default: s_size = 33'd4;
    endcase

    s_misalign = ((s_f3[1:0] == 2'b01) && s_addr[0]) ||
                 ((s_f3[1:0] == 2'b10) && (s_addr[1:0] != 2'b00));
    // 33-bit compare: an address near 2^32 plus size must not wrap to legal
    s_oor = {1'b0, s_addr} > (33'(DEPTH) - s_size);
    s_err = !s_legal || s_misalign || s_oor;
  end

  // Next-state; strobes and acks are registered so they are high exactly
  // during the ACCESS / ACK cycles and drop with reset immediately.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    err_d        = err_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          sel_d        = pick;
          last_grant_d = pick;
          we_d         = s_we;
          addr_d       = s_addr;
          wdata_d      = s_wdata;
          f3_d         = s_f3;
          err_d        = s_err;
          mem_read_d   = !s_err && !s_we;
          mem_write_d  = !s_err && s_we;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        state_d = ACK;
        if (!sel_q) begin
          ack0_d   = 1'b1;
          err0_d   = err_q;
          rdata0_d = (we_q || err_q) ? '0 : bus.mem_data_out;
        end else begin
          ack1_d   = 1'b1;
          err1_d   = err_q;
          rdata1_d = (we_q || err_q) ? '0 : bus.mem_data_out;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f3_q         <= f3_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.err0           = err0_q;
  assign bus.err1           = err1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_func3      = f3_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  logic init_req;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory model: combinational read with func3 extension, write at posedge
  logic [7:0] mem [1024];
  logic [9:0] ma;
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    ma = bus.mem_addr[9:0];
    b0 = mem[ma];
    b1 = mem[ma + 10'd1];
    b2 = mem[ma + 10'd2];
    b3 = mem[ma + 10'd3];
    case (bus.mem_func3)
      3'b000:  bus.mem_data_out = {{24{b0[7]}}, b0};
      3'b001:  bus.mem_data_out = {{16{b1[7]}}, b1, b0};
      3'b010:  bus.mem_data_out = {b3, b2, b1, b0};
      3'b100:  bus.mem_data_out = {24'h0, b0};
      3'b101:  bus.mem_data_out = {16'h0, b1, b0};
      default: bus.mem_data_out = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem[16] <= 8'hEF;
      mem[17] <= 8'hBE;
      mem[18] <= 8'hAD;
      mem[19] <= 8'hDE;
    end else if (bus.mem_write) begin
      mem[ma] <= bus.mem_write_data[7:0];
      if (bus.mem_func3[1:0] != 2'b00) mem[ma + 10'd1] <= bus.mem_write_data[15:8];
      if (bus.mem_func3[1:0] == 2'b10) begin
        mem[ma + 10'd2] <= bus.mem_write_data[23:16];
        mem[ma + 10'd3] <= bus.mem_write_data[31:24];
      end
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          rd;
    int          wr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_port_log[$];
  int   ack_cyc_log[$];
  int   errors = 0;
  int   checks = 0;
  int   viol = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_ack(input int p, input logic err, input logic [31:0] rdata);
    exp_t e;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack%0d: got ack at cycle %0d expected none", p, cyc);
    end else begin
      e = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("err%0d", p), 32'(err), 32'(e.err));
      chk($sformatf("rdata%0d", p), rdata, e.rdata);
      chk($sformatf("rd_strobes%0d", p), 32'(rd_cnt), 32'(e.rd));
      chk($sformatf("wr_strobes%0d", p), 32'(wr_cnt), 32'(e.wr));
    end
    rd_cnt = 0;
    wr_cnt = 0;
    ack_port_log.push_back(p);
    ack_cyc_log.push_back(cyc);
  endtask

  // Output monitor: pops the scoreboard on every ack, tracks strobes
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (bus.mem_read && bus.mem_write) viol++;
        if (bus.ack0 && bus.ack1) viol++;
        if (bus.mem_read) rd_cnt++;
        if (bus.mem_write) wr_cnt++;
        if (bus.ack0) check_ack(0, bus.err0, bus.rdata0);
        if (bus.ack1) check_ack(1, bus.err1, bus.rdata1);
      end
    end
  end

  function automatic vec_t mk(bit p, bit we, logic [31:0] a, logic [31:0] wd,
                              logic [2:0] f3, bit e, logic [31:0] rd);
    vec_t v;
    v.port = p; v.we = we; v.addr = a; v.wdata = wd; v.f3 = f3;
    v.exp_err = e; v.exp_rdata = rd;
    return v;
  endfunction

  // Drive one request, push its expectation, wait (bounded) for its ack.
  // keep=1 leaves req high after the ack edge for back-to-back traffic.
  task automatic run_txn(input vec_t v, input bit keep, input bit chk_lat);
    exp_t e;
    exp_t dummy;
    int   n;
    bit   got;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    e.rd    = (!v.exp_err && !v.we) ? 1 : 0;
    e.wr    = (!v.exp_err && v.we) ? 1 : 0;
    if (!v.port) begin
      bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata; bus.f3_0 = v.f3;
      bus.req0 = 1'b1;
      q0.push_back(e);
    end else begin
      bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata; bus.f3_1 = v.f3;
      bus.req1 = 1'b1;
      q1.push_back(e);
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      got = v.port ? bus.ack1 : bus.ack0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout_port%0d: got no ack in %0d cycles expected ack", v.port, n);
      if (!v.port && q0.size() > 0) dummy = q0.pop_back();
      if (v.port && q1.size() > 0) dummy = q1.pop_back();
    end else if (chk_lat) begin
      chk($sformatf("latency_port%0d", v.port), 32'(n), 32'd3);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (!v.port) bus.req0 = 1'b0;
      else         bus.req1 = 1'b0;
    end
  endtask

  vec_t vecs[17];
  int   base;

  initial begin
    vecs[0]  = mk(0, 0, 32'h10,       32'h0,        3'b010, 0, 32'hDEADBEEF);
    vecs[1]  = mk(1, 1, 32'h5,        32'h12345680, 3'b000, 0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h5,        32'h0,        3'b100, 0, 32'h00000080);
    vecs[3]  = mk(1, 0, 32'h5,        32'h0,        3'b000, 0, 32'hFFFFFF80);
    vecs[4]  = mk(0, 0, 32'h4,        32'h0,        3'b010, 0, 32'h5D5C805E);
    vecs[5]  = mk(0, 0, 32'h102,      32'h0,        3'b010, 1, 32'h0);
    vecs[6]  = mk(1, 1, 32'h3FF,      32'hFFFF,     3'b001, 1, 32'h0);
    vecs[7]  = mk(0, 0, 32'h20,       32'h0,        3'b011, 1, 32'h0);
    vecs[8]  = mk(1, 1, 32'hFFFFFFFC, 32'h1,        3'b010, 1, 32'h0);
    vecs[9]  = mk(0, 1, 32'h3FC,      32'hCAFEF00D, 3'b010, 0, 32'h0);
    vecs[10] = mk(1, 0, 32'h3FC,      32'h0,        3'b010, 0, 32'hCAFEF00D);
    vecs[11] = mk(0, 0, 32'h3FE,      32'h0,        3'b001, 0, 32'hFFFFCAFE);
    vecs[12] = mk(1, 0, 32'h3FE,      32'h0,        3'b101, 0, 32'h0000CAFE);
    vecs[13] = mk(0, 0, 32'h400,      32'h0,        3'b000, 1, 32'h0);
    vecs[14] = mk(1, 1, 32'h8,        32'h0,        3'b100, 1, 32'h0);
    vecs[15] = mk(0, 0, 32'h11,       32'h0,        3'b101, 1, 32'h0);
    vecs[16] = mk(0, 0, 32'h3FF,      32'h0,        3'b100, 0, 32'h000000CA);

    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.f3_0 = 0; bus.f3_1 = 0;
    rst = 1'b0;
    init_req = 1'b0;
    #2;
    rst = 1'b1;
    init_req = 1'b1;
    #1;
    chk("rst_ack0", 32'(bus.ack0), 32'd0);
    chk("rst_ack1", 32'(bus.ack1), 32'd0);
    chk("rst_err0", 32'(bus.err0), 32'd0);
    chk("rst_err1", 32'(bus.err1), 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
    chk("rst_mem_func3", 32'(bus.mem_func3), 32'd0);
    @(posedge clk);
    #1;
    init_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) run_txn(vecs[i], 1'b0, 1'b1);

    // Back-to-back on port 0: new fields applied right after the ack edge
    ack_cyc_log.delete();
    run_txn(mk(0, 0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF), 1'b1, 1'b1);
    run_txn(mk(0, 0, 32'h13, 32'h0, 3'b100, 0, 32'h000000DE), 1'b0, 1'b1);
    if (ack_cyc_log.size() == 2) chk("b2b_spacing", 32'(ack_cyc_log[1] - ack_cyc_log[0]), 32'd3);
    else chk("b2b_acks", 32'(ack_cyc_log.size()), 32'd2);

    // Contention after reset: grants must alternate starting with port 0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ack_port_log.delete();
    ack_cyc_log.delete();
    fork
      begin
        run_txn(mk(0, 1, 32'h20, 32'h11223344, 3'b010, 0, 32'h0), 1'b1, 1'b0);
        run_txn(mk(0, 0, 32'h28, 32'h0, 3'b010, 0, 32'h71707372), 1'b0, 1'b0);
      end
      begin
        run_txn(mk(1, 0, 32'h20, 32'h0, 3'b010, 0, 32'h11223344), 1'b1, 1'b0);
        run_txn(mk(1, 1, 32'h24, 32'h55667788, 3'b010, 0, 32'h0), 1'b0, 1'b0);
      end
    join
    chk("contention_acks", 32'(ack_port_log.size()), 32'd4);
    if (ack_port_log.size() == 4) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("grant_order_%0d", k), 32'(ack_port_log[k]), 32'(k % 2));
      chk("contention_span", 32'(ack_cyc_log[3] - ack_cyc_log[0]), 32'd9);
    end

    // Reset during ACCESS of a port 0 store: strobe drops, no ack, no write
    bus.we0 = 1'b1; bus.addr0 = 32'h30; bus.wdata0 = 32'hAAAAAAAA; bus.f3_0 = 3'b010;
    bus.req0 = 1'b1;
    @(posedge clk);
    #1;
    chk("access_mem_write", 32'(bus.mem_write), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mid_mem_read", 32'(bus.mem_read), 32'd0);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    base = ack_port_log.size();
    repeat (4) @(negedge clk);
    chk("rst_mid_no_ack", 32'(ack_port_log.size()), 32'(base));
    @(posedge clk);
    #1;
    fork
      run_txn(mk(0, 0, 32'h30, 32'h0, 3'b010, 0, 32'h69686B6A), 1'b0, 1'b0);
      run_txn(mk(1, 0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF), 1'b0, 1'b0);
    join
    chk("post_rst_acks", 32'(ack_port_log.size()), 32'(base + 2));
    if (ack_port_log.size() == base + 2)
      chk("post_rst_first_grant", 32'(ack_port_log[base]), 32'd0);

    repeat (2) @(negedge clk);
    chk("no_overlap", 32'(viol), 32'd0);
    chk("sb_empty0", 32'(q0.size()), 32'd0);
    chk("sb_empty1", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and sequencer in front of the byte-addressed data memory. It lets the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1) share the single memory port. Each granted access is checked for alignment, range and func3 legality, then driven as exactly one exclusive read or write strobe. The result is returned with a one-cycle acknowledge.

## Interface
- DEPTH, 1024, memory size in bytes; legal byte addresses 0..DEPTH-1
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request; held with fields stable until ack
- we0 / we1  in  1  1 = store, 0 = load
- addr0 / addr1  in  32  byte address
- wdata0 / wdata1  in  32  store data, little-endian, low bytes used for SB/SH
- f3_0 / f3_1  in  3  RISC-V func3 (`F3_* encodings)
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack; 1 = access rejected, memory untouched
- rdata0 / rdata1  out  32  load result, valid with ack; 0 for stores and errors
- mem_addr  out  32  to memory addr
- mem_write_data  out  32  to memory write_data
- mem_func3  out  3  to memory func3
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_data_out  in  32  from memory data_out (combinational read)

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE, no req: stay.
- IDLE, any req: select a port, latch its we/addr/wdata/f3 and the port id, compute err, go to ACCESS.
- Selection with both req: the port not granted last (last_grant register). Selection with one req: that port. last_grant updates on every selection.
- ACCESS: if err=0, assert exactly one of mem_read (we=0) or mem_write (we=1) for this one cycle. mem_data_out is captured into the port's rdata register at the end of the cycle. Then go to ACK.
- ACK: assert ack and err for the latched port only. rdata holds the captured value; it is forced to 0 if we=1 or err=1. Then go to IDLE.
- err sources:
  - illegal func3. Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores: SB 000, SH 001, SW 010.
  - misalignment: halfword with addr[0]≠0, word with addr[1:0]≠0.
  - range: addr > DEPTH − size, with size 1/2/4. Compare in 33-bit arithmetic so that addresses near 2^32 cannot wrap.
- mem_addr, mem_write_data and mem_func3 hold the latched values outside ACCESS. Only the strobes gate the memory.
- A req still high in IDLE after an ack is treated as a new request (back-to-back allowed).
- The non-selected port's req is ignored until the next IDLE. Its fields are not sampled.

## Timing
- Reset (async, immediate): state IDLE, last_grant=1 so port 0 wins the first tie. All outputs 0: ack*, err*, rdata*, mem_read, mem_write, mem_addr, mem_write_data, mem_func3.
- Reset during ACCESS or ACK: strobes and ack drop immediately. The transaction is abandoned and no ack is ever issued for it.
- Latency: req sampled high in IDLE at edge N → ACCESS in cycle N+1 → ack high in cycle N+2.
- Throughput: one access per 3 cycles. With both ports continuously requesting, grants alternate 0,1,0,1.
- The memory write commits at the edge ending ACCESS. A load by the other port in the next transaction sees the new data.
- mem_read and mem_write are never high together and never high outside ACCESS.
- ack0 and ack1 are never high together.

## Test plan
- Single load: memory preloaded with 0xDEADBEEF at addr 0x10; port 0 requests LW at 0x10 → mem_read high in exactly one cycle; ack0 two cycles after req; rdata0=0xDEADBEEF; err0=0.
- Store/readback: port 1 SB 0x80 at addr 5, then LBU addr 5, then LB addr 5 → rdata1 = 0x00000080, then 0xFFFFFF80; other bytes unchanged.
- Contention: req0 and req1 held high with independent SW/LW streams for 12 cycles → after reset, grant order is 0,1,0,1; exactly 4 acks; no cycle with both acks or both strobes.
- Errors: LW at 0x102; SH at 0x3FF with DEPTH=1024; f3=011 load; SW at 0xFFFFFFFC → each gives ack with err=1, rdata=0, mem_read/mem_write never asserted.
- Reset mid-op: assert rst during ACCESS of a port 0 SW → strobes 0 immediately; no ack0; after release, a tie grants port 0 first.
- Back-to-back: port 0 keeps req high and changes fields at the ack edge → the next transaction starts in the following IDLE cycle with the new fields.
